// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: register/ALU-op widths and the decoded control bundle
// carried from ID into EX.
package cpu_pipe_pkg;

  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  typedef struct packed {
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemToReg;
    logic               RegDst;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
  } ctrl_t;

  // A bubble must never write state or touch memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load currently in EX. Suppressed while ID is being flushed.
module load_use_detect
  import cpu_pipe_pkg::*;
(
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rt,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic              i_branch_flush,
  output logic              o_stall
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_id_uses_rs && (i_ex_rt == i_id_rs);
  assign w_rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);

  // Register 0 is hard-wired, so a load into it can never create a dependency.
  assign o_stall = i_ex_memread && (i_ex_rt != '0) && (w_rs_hit || w_rt_hit)
                   && !i_branch_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and WB->ID bypass.
// Optional perf counters (StallCount/FlushCount) when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = cpu_pipe_pkg::REG_AW,
  parameter int ALUOP_W = cpu_pipe_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_AW-1:0]  ID_rs,
  input  logic [REG_AW-1:0]  ID_rt,
  input  logic [REG_AW-1:0]  ID_rd,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemToReg,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               BranchFlush,
  input  logic               WB_RegWrite,
  input  logic [REG_AW-1:0]  WB_WriteRegister,
  input  logic [DATA_W-1:0]  WB_WriteData,
  output logic [REG_AW-1:0]  EX_rs,
  output logic [REG_AW-1:0]  EX_rt,
  output logic [REG_AW-1:0]  EX_rd,
  output logic [DATA_W-1:0]  EX_ReadData1,
  output logic [DATA_W-1:0]  EX_ReadData2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic               EX_RegWrite,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_MemToReg,
  output logic               EX_ALUSrc,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [REG_AW-1:0]  EX_WriteRegister,
  output logic               PCWrite,
  output logic               IFID_Write,
  output logic               Stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        StallCount,
  output logic [31:0]        FlushCount
`endif
);

  import cpu_pipe_pkg::*;

  ctrl_t              r_ctrl;
  logic [REG_AW-1:0]  r_rs, r_rt, r_rd;
  logic [DATA_W-1:0]  r_rd1, r_rd2, r_imm;

  ctrl_t              w_id_ctrl;
  logic               w_stall;
  logic               w_byp_rs, w_byp_rt;
  logic [DATA_W-1:0]  w_op1, w_op2;

  load_use_detect u_load_use_detect (
    .i_ex_memread   (r_ctrl.MemRead),
    .i_ex_rt        (r_rt),
    .i_id_rs        (ID_rs),
    .i_id_rt        (ID_rt),
    .i_id_uses_rs   (ID_UsesRs),
    .i_id_uses_rt   (ID_UsesRt),
    .i_branch_flush (BranchFlush),
    .o_stall        (w_stall)
  );

  always_comb begin
    // NOTE: every field gets a value on every path, so no latch can be inferred.
    w_id_ctrl          = CTRL_BUBBLE;
    w_id_ctrl.RegWrite = ID_RegWrite;
    w_id_ctrl.MemRead  = ID_MemRead;
    w_id_ctrl.MemWrite = ID_MemWrite;
    w_id_ctrl.MemToReg = ID_MemToReg;
    w_id_ctrl.RegDst   = ID_RegDst;
    w_id_ctrl.ALUSrc   = ID_ALUSrc;
    w_id_ctrl.ALUOp    = ID_ALUOp;
  end

  // The register file is written at the end of WB, so the same-cycle read is stale.
  assign w_byp_rs = WB_RegWrite && (WB_WriteRegister != '0) && (WB_WriteRegister == ID_rs);
  assign w_byp_rt = WB_RegWrite && (WB_WriteRegister != '0) && (WB_WriteRegister == ID_rt);
  assign w_op1    = w_byp_rs ? WB_WriteData : ID_ReadData1;
  assign w_op2    = w_byp_rt ? WB_WriteData : ID_ReadData2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= CTRL_BUBBLE;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
    end else if (BranchFlush || w_stall) begin
      r_ctrl <= CTRL_BUBBLE;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_imm  <= '0;
    end else begin
      r_ctrl <= w_id_ctrl;
      r_rs   <= ID_rs;
      r_rt   <= ID_rt;
      r_rd   <= ID_rd;
      r_rd1  <= w_op1;
      r_rd2  <= w_op2;
      r_imm  <= ID_Imm;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)     r_stall_cnt <= r_stall_cnt + 32'd1;
      if (BranchFlush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`endif

  assign EX_rs            = r_rs;
  assign EX_rt            = r_rt;
  assign EX_rd            = r_rd;
  assign EX_ReadData1     = r_rd1;
  assign EX_ReadData2     = r_rd2;
  assign EX_Imm           = r_imm;
  assign EX_RegWrite      = r_ctrl.RegWrite;
  assign EX_MemRead       = r_ctrl.MemRead;
  assign EX_MemWrite      = r_ctrl.MemWrite;
  assign EX_MemToReg      = r_ctrl.MemToReg;
  assign EX_ALUSrc        = r_ctrl.ALUSrc;
  assign EX_ALUOp         = r_ctrl.ALUOp;
  assign EX_WriteRegister = r_ctrl.RegDst ? r_rd : r_rt;
  assign Stall            = w_stall;
  assign PCWrite          = !w_stall;
  assign IFID_Write       = !w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (default build, counters off).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs, ID_rt, ID_rd;
  logic        ID_UsesRs, ID_UsesRt;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_RegDst, ID_ALUSrc;
  logic [3:0]  ID_ALUOp;
  logic        BranchFlush;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData;
  logic [4:0]  EX_rs, EX_rt, EX_rd, EX_WriteRegister;
  logic [31:0] EX_ReadData1, EX_ReadData2, EX_Imm;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
  logic [3:0]  EX_ALUOp;
  logic        PCWrite, IFID_Write, Stall;

  int pass_cnt  = 0;
  int total_cnt = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemToReg(ID_MemToReg), .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .BranchFlush(BranchFlush),
    .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister), .WB_WriteData(WB_WriteData),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
    .EX_WriteRegister(EX_WriteRegister),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .Stall(Stall)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] rs, rt, rd, input logic urs, urt,
                          input logic [31:0] rd1, rd2, imm,
                          input logic rw, mr, mw, m2r, rdst, asrc, input logic [3:0] aop);
    ID_rs = rs; ID_rt = rt; ID_rd = rd; ID_UsesRs = urs; ID_UsesRt = urt;
    ID_ReadData1 = rd1; ID_ReadData2 = rd2; ID_Imm = imm;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw; ID_MemToReg = m2r;
    ID_RegDst = rdst; ID_ALUSrc = asrc; ID_ALUOp = aop;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1; BranchFlush = 1'b0;
    drive_id(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, $urandom, $urandom,
             $urandom, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom));
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'($urandom); WB_WriteData = $urandom;
    tick(); tick();
    got = {17'd0, EX_rs, EX_rt, EX_rd};
    total_cnt++; if (got !== 32'd0) $display("FAIL reset_regs got %h exp 0", got); else pass_cnt++;
    total_cnt++; if ((EX_ReadData1 | EX_ReadData2 | EX_Imm) !== 32'd0)
      $display("FAIL reset_data got %h/%h/%h exp 0", EX_ReadData1, EX_ReadData2, EX_Imm); else pass_cnt++;
    got = {20'd0, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp, EX_WriteRegister[2:0]};
    total_cnt++; if (got !== 32'd0 || EX_WriteRegister !== 5'd0)
      $display("FAIL reset_ctrl got %h wr %0d exp 0", got, EX_WriteRegister); else pass_cnt++;
    total_cnt++; if ({PCWrite, IFID_Write, Stall} !== 3'b110)
      $display("FAIL reset_hazard got %b exp 110", {PCWrite, IFID_Write, Stall}); else pass_cnt++;
    rst = 1'b0; WB_RegWrite = 1'b0; WB_WriteRegister = '0; WB_WriteData = '0;
  endtask

  task automatic test_pass_through();
    drive_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'h11, 32'h22, 32'h7,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    tick();
    total_cnt++; if ({EX_rs, EX_rt, EX_rd, EX_WriteRegister} !== {5'd3, 5'd4, 5'd5, 5'd5})
      $display("FAIL pass_regs got %0d/%0d/%0d/%0d exp 3/4/5/5", EX_rs, EX_rt, EX_rd, EX_WriteRegister); else pass_cnt++;
    total_cnt++; if ({EX_ReadData1, EX_ReadData2, EX_Imm} !== {32'h11, 32'h22, 32'h7})
      $display("FAIL pass_data got %h/%h/%h exp 11/22/7", EX_ReadData1, EX_ReadData2, EX_Imm); else pass_cnt++;
    total_cnt++; if ({EX_ALUOp, EX_RegWrite, EX_MemRead, EX_ALUSrc} !== {4'd2, 3'b100})
      $display("FAIL pass_ctrl got aluop %0d rw %b mr %b as %b exp 2 1 0 0", EX_ALUOp, EX_RegWrite, EX_MemRead, EX_ALUSrc); else pass_cnt++;
    drive_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 32'h33, 32'h0, 32'h9,
             1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    tick();
    total_cnt++; if (EX_WriteRegister !== 5'd4)
      $display("FAIL pass_regdst0 got %0d exp 4", EX_WriteRegister); else pass_cnt++;
    total_cnt++; if ({EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp} !== {3'b111, 4'd9})
      $display("FAIL pass_ctrl2 got %b%b%b aluop %0d exp 111 9", EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_ALUOp); else pass_cnt++;
  endtask

  task automatic test_load_use();
    // lw r8 <- (r1): enters EX
    drive_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h4,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive_id(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 32'hA, 32'hB, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    #1;
    total_cnt++; if ({Stall, PCWrite, IFID_Write} !== 3'b100)
      $display("FAIL lu_rs_stall got %b exp 100", {Stall, PCWrite, IFID_Write}); else pass_cnt++;
    tick();
    total_cnt++; if ({EX_RegWrite, EX_MemRead, EX_rt, EX_rs, EX_ReadData1} !== 44'd0)
      $display("FAIL lu_bubble got rw %b mr %b rt %0d rs %0d d1 %h exp 0", EX_RegWrite, EX_MemRead, EX_rt, EX_rs, EX_ReadData1); else pass_cnt++;
    total_cnt++; if ({Stall, PCWrite} !== 2'b01)
      $display("FAIL lu_release got %b exp 01", {Stall, PCWrite}); else pass_cnt++;
    tick();
    total_cnt++; if ({EX_rs, EX_WriteRegister, EX_ReadData1} !== {5'd8, 5'd10, 32'hA})
      $display("FAIL lu_advance got rs %0d wr %0d d1 %h exp 8 10 a", EX_rs, EX_WriteRegister, EX_ReadData1); else pass_cnt++;
    // dependency through rt
    drive_id(5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive_id(5'd2, 5'd7, 5'd11, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    #1;
    total_cnt++; if ({Stall, IFID_Write} !== 2'b10)
      $display("FAIL lu_rt_stall got %b exp 10", {Stall, IFID_Write}); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if ({EX_rt, EX_rd} !== {5'd7, 5'd11})
      $display("FAIL lu_rt_advance got %0d/%0d exp 7/11", EX_rt, EX_rd); else pass_cnt++;
  endtask

  task automatic test_no_false_stall();
    drive_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive_id(5'd8, 5'd8, 5'd12, 1'b0, 1'b0, 32'h5, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    #1;
    total_cnt++; if ({Stall, PCWrite} !== 2'b01)
      $display("FAIL nfs_unused got %b exp 01", {Stall, PCWrite}); else pass_cnt++;
    tick();
    total_cnt++; if ({EX_rs, EX_rd, EX_ALUOp} !== {5'd8, 5'd12, 4'd3})
      $display("FAIL nfs_unused_load got %0d/%0d/%0d exp 8/12/3", EX_rs, EX_rd, EX_ALUOp); else pass_cnt++;
    // load targeting r0 never stalls
    drive_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
             1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive_id(5'd0, 5'd0, 5'd13, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    #1;
    total_cnt++; if (Stall !== 1'b0)
      $display("FAIL nfs_r0 got %b exp 0", Stall); else pass_cnt++;
    tick();
    total_cnt++; if ({EX_rd, EX_ALUOp} !== {5'd13, 4'd4})
      $display("FAIL nfs_r0_load got %0d/%0d exp 13/4", EX_rd, EX_ALUOp); else pass_cnt++;
  endtask

  task automatic test_flush_priority();
    drive_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive_id(5'd8, 5'd3, 5'd14, 1'b1, 1'b1, 32'h55, 32'h66, 32'h77,
             1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    BranchFlush = 1'b1;
    #1;
    total_cnt++; if ({Stall, PCWrite, IFID_Write} !== 3'b011)
      $display("FAIL flush_nostall got %b exp 011", {Stall, PCWrite, IFID_Write}); else pass_cnt++;
    tick();
    BranchFlush = 1'b0;
    total_cnt++; if ({EX_RegWrite, EX_MemWrite, EX_ALUSrc, EX_ALUOp, EX_rs, EX_rt, EX_rd, EX_ReadData1, EX_Imm} !== 86'd0)
      $display("FAIL flush_bubble got rw %b mw %b rs %0d rd %0d d1 %h exp 0", EX_RegWrite, EX_MemWrite, EX_rs, EX_rd, EX_ReadData1); else pass_cnt++;
  endtask

  task automatic test_bypass();
    drive_id(5'd6, 5'd6, 5'd2, 1'b1, 1'b1, 32'h5, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    WB_RegWrite = 1'b1; WB_WriteRegister = 5'd6; WB_WriteData = 32'hDEAD;
    tick();
    total_cnt++; if (EX_ReadData2 !== 32'hDEAD)
      $display("FAIL byp_rt got %h exp dead", EX_ReadData2); else pass_cnt++;
    total_cnt++; if (EX_ReadData1 !== 32'hDEAD)
      $display("FAIL byp_rs got %h exp dead", EX_ReadData1); else pass_cnt++;
    ID_rs = 5'd0; ID_rt = 5'd0; ID_ReadData1 = 32'h0; ID_ReadData2 = 32'h1234; WB_WriteRegister = 5'd0;
    tick();
    total_cnt++; if ({EX_ReadData1, EX_ReadData2} !== {32'h0, 32'h1234})
      $display("FAIL byp_r0 got %h/%h exp 0/1234", EX_ReadData1, EX_ReadData2); else pass_cnt++;
    ID_rt = 5'd6; ID_ReadData2 = 32'h0; WB_WriteRegister = 5'd6; WB_RegWrite = 1'b0;
    tick();
    total_cnt++; if (EX_ReadData2 !== 32'h0)
      $display("FAIL byp_nowrite got %h exp 0", EX_ReadData2); else pass_cnt++;
    WB_RegWrite = 1'b1; BranchFlush = 1'b1;
    tick();
    BranchFlush = 1'b0;
    total_cnt++; if (EX_ReadData2 !== 32'h0)
      $display("FAIL byp_bubble got %h exp 0", EX_ReadData2); else pass_cnt++;
    WB_RegWrite = 1'b0; WB_WriteRegister = '0; WB_WriteData = '0;
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    drive_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    // lw r9 <- (r8): depends on the first load
    drive_id(5'd8, 5'd9, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    #1; stalls += int'(Stall);
    tick(); stalls += int'(Stall);
    tick();
    total_cnt++; if ({EX_MemRead, EX_rs, EX_rt} !== {1'b1, 5'd8, 5'd9})
      $display("FAIL b2b_second_load got mr %b rs %0d rt %0d exp 1 8 9", EX_MemRead, EX_rs, EX_rt); else pass_cnt++;
    drive_id(5'd9, 5'd2, 5'd15, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
    #1; stalls += int'(Stall);
    tick(); stalls += int'(Stall);
    tick(); stalls += int'(Stall);
    total_cnt++; if (stalls !== 2)
      $display("FAIL b2b_stall_count got %0d exp 2", stalls); else pass_cnt++;
    total_cnt++; if ({EX_rs, EX_WriteRegister, EX_ALUOp} !== {5'd9, 5'd15, 4'd6})
      $display("FAIL b2b_consumer got %0d/%0d/%0d exp 9/15/6", EX_rs, EX_WriteRegister, EX_ALUOp); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    drive_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    drive_id(5'd8, 5'd4, 5'd16, 1'b1, 1'b1, 32'h99, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7);
    #1;
    total_cnt++; if (Stall !== 1'b1)
      $display("FAIL rms_pre got %b exp 1", Stall); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if ({EX_MemRead, EX_rt, Stall, PCWrite} !== {1'b0, 5'd0, 2'b01})
      $display("FAIL rms_clear got mr %b rt %0d st %b pc %b exp 0 0 0 1", EX_MemRead, EX_rt, Stall, PCWrite); else pass_cnt++;
    tick();
    total_cnt++; if ({EX_rs, EX_rd, EX_ReadData1} !== {5'd8, 5'd16, 32'h99})
      $display("FAIL rms_advance got %0d/%0d/%h exp 8/16/99", EX_rs, EX_rd, EX_ReadData1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_stall();
    test_flush_priority();
    test_bypass();
    test_back_to_back();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
